// File: rtl/normalizer_multi.sv
// Multi-channel column normalizer: gathers one COL-element vector per channel,
// reduces all elements to a (signed or absolute) sum, then streams x/sum per element index.

module normalizer_lane #(
  parameter int BW_PSUM = 16,
  parameter int COL     = 8,
  parameter int FRAC    = 8,
  parameter int W_OUT   = 16,
  parameter int W_SUM   = 21
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cap,
  input  logic                     rot,
  input  logic [COL*BW_PSUM-1:0]   din,
  input  logic signed [W_SUM-1:0]  sum,
  output logic [BW_PSUM-1:0]       head,
  output logic [W_OUT-1:0]         quot
);
  localparam int NW = BW_PSUM + FRAC;
  localparam int DW = ((NW > W_SUM) ? NW : W_SUM) + 1;
  localparam logic signed [DW-1:0] QMAX = {{(DW-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
  localparam logic signed [DW-1:0] QMIN = {{(DW-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};

  logic [COL-1:0][BW_PSUM-1:0] sr;
  logic signed [DW-1:0] num, den, q;

  // Rotating by one element per cycle keeps the current element at slot 0;
  // COL rotations restore the original order.
  always_ff @(posedge clk) begin
    if (reset)    sr <= '0;
    else if (cap) sr <= din;
    else if (rot) sr <= {sr[0], sr[COL-1:1]};
  end

  assign head = sr[0];
  assign num  = DW'($signed(sr[0])) <<< FRAC;
  assign den  = DW'(sum);

  always_comb begin
    q = '0;
    if (den != '0) q = num / den;
    if (q > QMAX)      quot = QMAX[W_OUT-1:0];
    else if (q < QMIN) quot = QMIN[W_OUT-1:0];
    else               quot = q[W_OUT-1:0];
  end
endmodule

module normalizer_multi #(
  parameter int BW_PSUM = 16,
  parameter int COL     = 8,
  parameter int N_CH    = 2,
  parameter int FRAC    = 8,
  parameter int W_OUT   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          abs_mode,
  input  logic [N_CH-1:0]               s_valid,
  output logic [N_CH-1:0]               s_ready,
  input  logic [N_CH*COL*BW_PSUM-1:0]   s_psum,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [N_CH*W_OUT-1:0]         m_norm,
  output logic [$clog2(COL)-1:0]        m_idx,
  output logic                          m_last,
  output logic                          m_div_zero
);
  localparam int W_SUM = BW_PSUM + $clog2(COL*N_CH) + 1;
  localparam int IW    = $clog2(COL);

  typedef enum logic [1:0] {COLLECT, SUM, DIV} state_t;

  state_t                      state;
  logic [N_CH-1:0]             got, cap;
  logic [IW-1:0]               count;
  logic signed [W_SUM-1:0]     sum, term, ext;
  logic                        mode, load, rot, cnt_last;
  logic [N_CH-1:0][BW_PSUM-1:0] head;
  logic [N_CH-1:0][W_OUT-1:0]   quot;

  assign s_ready  = ~got;
  assign cap      = s_valid & ~got & {N_CH{state == COLLECT}};
  assign load     = (state == DIV) && (!m_valid || m_ready);
  assign rot      = (state == SUM) || load;
  assign cnt_last = (count == IW'(COL-1));
  assign m_last   = (m_idx == IW'(COL-1));

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    normalizer_lane #(
      .BW_PSUM(BW_PSUM), .COL(COL), .FRAC(FRAC), .W_OUT(W_OUT), .W_SUM(W_SUM)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .cap  (cap[c]),
      .rot  (rot),
      .din  (s_psum[c*COL*BW_PSUM +: COL*BW_PSUM]),
      .sum  (sum),
      .head (head[c]),
      .quot (quot[c])
    );
  end

  // Per-cycle contribution of the current element of every channel.
  always_comb begin
    term = '0;
    ext  = '0;
    for (int c = 0; c < N_CH; c++) begin
      ext  = W_SUM'($signed(head[c]));
      term = term + ((mode && ext < 0) ? -ext : ext);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= COLLECT;
      got        <= '0;
      count      <= '0;
      sum        <= '0;
      mode       <= 1'b0;
      m_valid    <= 1'b0;
      m_idx      <= '0;
      m_norm     <= '0;
      m_div_zero <= 1'b0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      case (state)
        COLLECT: begin
          got <= got | cap;
          if (&(got | cap)) begin
            sum   <= '0;
            mode  <= abs_mode;
            count <= '0;
            state <= SUM;
          end
        end
        SUM: begin
          sum <= sum + term;
          if (cnt_last) begin
            count <= '0;
            state <= DIV;
          end else begin
            count <= count + 1'b1;
          end
        end
        DIV: begin
          if (load) begin
            m_norm     <= quot;
            m_idx      <= count;
            m_div_zero <= (sum == '0);
            m_valid    <= 1'b1;
            if (cnt_last) begin
              count <= '0;
              got   <= '0;
              state <= COLLECT;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_normalizer_multi.sv
// Scoreboard bench for normalizer_multi: expected beats queued at stimulus time,
// a negedge monitor pops and compares on every output handshake.

module tb_normalizer_multi;
  localparam int BW = 16, COL = 8, NCH = 2, FRAC = 8, WO = 16;

  logic                  clk = 1'b0;
  logic                  reset, abs_mode, m_valid, m_ready, m_last, m_div_zero;
  logic [NCH-1:0]        s_valid, s_ready;
  logic [NCH*COL*BW-1:0] s_psum;
  logic [NCH*WO-1:0]     m_norm;
  logic [2:0]            m_idx;

  always #5 clk = ~clk;

  normalizer_multi #(.BW_PSUM(BW), .COL(COL), .N_CH(NCH), .FRAC(FRAC), .W_OUT(WO)) dut (
    .clk(clk), .reset(reset), .abs_mode(abs_mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_psum(s_psum),
    .m_valid(m_valid), .m_ready(m_ready), .m_norm(m_norm),
    .m_idx(m_idx), .m_last(m_last), .m_div_zero(m_div_zero)
  );

  typedef struct {logic [NCH*WO-1:0] norm; int idx; bit dz;} exp_t;
  typedef int vec_t[COL];

  exp_t           sbq[$];
  exp_t           mon_e;
  int             errors = 0, checks = 0;
  bit             prev_stall = 1'b0;
  logic [NCH*WO+3:0] held;
  vec_t           v0, v1, q0, q1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [COL*BW-1:0] pack(input vec_t a);
    logic [COL*BW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = a[i][BW-1:0];
    return r;
  endfunction

  task automatic push_frame(input vec_t e0, input vec_t e1, input bit dz, input int nb);
    exp_t e;
    for (int i = 0; i < nb; i++) begin
      e.norm = {e1[i][WO-1:0], e0[i][WO-1:0]};
      e.idx  = i;
      e.dz   = dz;
      sbq.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (s_ready != 2'b11 && n < 100) begin
      tick();
      n++;
    end
    check("s_ready_idle", 64'(s_ready), 64'(2'b11));
  endtask

  task automatic send_frame(input vec_t a0, input vec_t a1, input int gap, input bit mode);
    wait_ready();
    abs_mode = mode;
    s_psum[0 +: COL*BW]      = pack(a0);
    s_psum[COL*BW +: COL*BW] = pack(a1);
    if (gap == 0) begin
      s_valid = 2'b11;
      tick();
      s_valid = 2'b00;
    end else begin
      s_valid = 2'b01;
      tick();
      s_valid = 2'b00;
      check("stagger_ready_first", 64'(s_ready), 64'(2'b10));
      repeat (gap - 1) tick();
      check("stagger_ready_last", 64'(s_ready), 64'(2'b10));
      s_valid = 2'b10;
      tick();
      s_valid = 2'b00;
    end
  endtask

  task automatic drain(input bit bp);
    int k = 0;
    while (sbq.size() != 0 && k < 400) begin
      if (bp) m_ready = (k % 4 == 0) || (k % 4 == 3);
      tick();
      k++;
    end
    m_ready = 1'b1;
    check("drain_empty", 64'(sbq.size()), 64'd0);
    tick();
    check("idle_after_frame", 64'(m_valid), 64'd0);
  endtask

  // Monitor: a beat is consumed at the next posedge when valid&&ready here.
  always @(negedge clk) begin
    if (m_valid && m_ready && !reset) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual idx=%0d norm=%0h required none", m_idx, m_norm);
      end else begin
        mon_e = sbq.pop_front();
        check("beat_norm", 64'(m_norm), 64'(mon_e.norm));
        check("beat_idx", 64'(m_idx), 64'(mon_e.idx));
        check("beat_last", 64'(m_last), 64'(mon_e.idx == COL-1));
        check("beat_div_zero", 64'(m_div_zero), 64'(mon_e.dz));
      end
    end
    if (prev_stall && m_valid)
      check("stall_hold", 64'({m_norm, m_idx, m_div_zero}), 64'(held));
    prev_stall = m_valid && !m_ready;
    held       = {m_norm, m_idx, m_div_zero};
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; abs_mode = 1'b0; s_valid = '0; s_psum = '0; m_ready = 1'b1;
    repeat (3) tick();
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'(2'b11));
    check("rst_m_idx", 64'(m_idx), 64'd0);
    check("rst_m_norm", 64'(m_norm), 64'd0);
    check("rst_div_zero", 64'(m_div_zero), 64'd0);
    reset = 1'b0;
    tick();

    // Basic: all ones, sum 16 -> 256/16 = 16
    v0 = '{1,1,1,1,1,1,1,1}; v1 = '{1,1,1,1,1,1,1,1};
    q0 = '{16,16,16,16,16,16,16,16}; q1 = q0;
    push_frame(q0, q1, 1'b0, COL);
    send_frame(v0, v1, 0, 1'b0);
    n = 0;
    while (!m_valid && n < 30) begin tick(); n++; end
    check("first_valid_latency", 64'(n), 64'd9);
    drain(1'b0);

    // Staggered arrival + backpressure: sum 36+28 = 64 -> q = 4*x
    v0 = '{1,2,3,4,5,6,7,8}; v1 = '{4,4,4,4,4,4,2,2};
    q0 = '{4,8,12,16,20,24,28,32}; q1 = '{16,16,16,16,16,16,8,8};
    push_frame(q0, q1, 1'b0, COL);
    send_frame(v0, v1, 5, 1'b0);
    drain(1'b1);

    // Saturation: sum 1
    v0 = '{200,0,0,0,0,0,0,0}; v1 = '{-199,0,0,0,0,0,0,0};
    q0 = '{32767,0,0,0,0,0,0,0}; q1 = '{-32768,0,0,0,0,0,0,0};
    push_frame(q0, q1, 1'b0, COL);
    send_frame(v0, v1, 0, 1'b0);
    drain(1'b0);

    // Signed sum of {4,-4} is 0; mode flipped during SUM must not matter
    v0 = '{4,-4,0,0,0,0,0,0}; v1 = '{0,0,0,0,0,0,0,0};
    q0 = '{0,0,0,0,0,0,0,0}; q1 = q0;
    push_frame(q0, q1, 1'b1, COL);
    send_frame(v0, v1, 0, 1'b0);
    abs_mode = 1'b1;
    drain(1'b0);

    // Absolute mode: sum 8 -> 128, -128
    q0 = '{128,-128,0,0,0,0,0,0}; q1 = '{0,0,0,0,0,0,0,0};
    push_frame(q0, q1, 1'b0, COL);
    send_frame(v0, v1, 0, 1'b1);
    abs_mode = 1'b0;
    drain(1'b0);

    // Reset during DIV beat 3 with m_ready low; only beats 0..2 are delivered
    v0 = '{1,2,3,4,5,6,7,8}; v1 = '{4,4,4,4,4,4,2,2};
    q0 = '{4,8,12,16,20,24,28,32}; q1 = '{16,16,16,16,16,16,8,8};
    push_frame(q0, q1, 1'b0, 3);
    send_frame(v0, v1, 0, 1'b0);
    n = 0;
    while (!(m_valid && m_idx == 3'd3) && n < 40) begin tick(); n++; end
    m_ready = 1'b0;
    check("reached_beat3", 64'({m_valid, m_idx}), 64'({1'b1, 3'd3}));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_m_valid", 64'(m_valid), 64'd0);
    check("midrst_s_ready", 64'(s_ready), 64'(2'b11));
    check("midrst_m_norm", 64'(m_norm), 64'd0);
    check("midrst_beats_left", 64'(sbq.size()), 64'd0);
    m_ready = 1'b1;
    v0 = '{1,1,1,1,1,1,1,1}; v1 = v0;
    q0 = '{16,16,16,16,16,16,16,16}; q1 = q0;
    push_frame(q0, q1, 1'b0, COL);
    send_frame(v0, v1, 0, 1'b0);
    drain(1'b0);

    // Back-to-back: frame B sum 3 must not inherit frame A's 16; truncation toward zero
    push_frame(q0, q1, 1'b0, COL);
    q0 = '{-85,0,0,0,0,0,0,0}; q1 = '{341,0,0,0,0,0,0,0};
    push_frame(q0, q1, 1'b0, COL);
    send_frame(v0, v1, 0, 1'b0);
    v0 = '{-1,0,0,0,0,0,0,0}; v1 = '{4,0,0,0,0,0,0,0};
    send_frame(v0, v1, 0, 1'b0);
    drain(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
